// File: rtl/hover_controller.sv
// Debounced 4x3 grid cursor; moves commit on FrameStart, select emits a pulse with the hovered index.
// Optional macro HOVER_WRAP_EN: edges wrap instead of saturating.
module hover_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DBC_WIDTH       = 19
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        KEY_UP,
  input  logic        KEY_DOWN,
  input  logic        KEY_LEFT,
  input  logic        KEY_RIGHT,
  input  logic        KEY_SEL,
  input  logic        FrameStart,
  output logic [11:0] HighlightedProductList,
  output logic [3:0]  HoverIndex,
  output logic        SelectPulse,
  output logic [3:0]  SelectIndex
);

  localparam int                   NKEYS = 5;
  localparam logic [DBC_WIDTH-1:0] LP_TC = DBC_WIDTH'(DEBOUNCE_CYCLES - 1);

  // key order: 0 up, 1 down, 2 left, 3 right, 4 select
  logic [NKEYS-1:0]                w_keys;
  logic [NKEYS-1:0]                r_sync1, r_sync2, r_stable, r_stable_d, r_evt;
  logic [NKEYS-1:0][DBC_WIDTH-1:0] r_cnt;
  logic [3:0]                      r_pend;
  logic [1:0]                      r_row, r_col;
  logic [3:0]                      r_hover_idx;
  logic [11:0]                     r_hover_list;
  logic                            r_sel_pulse;
  logic [3:0]                      r_sel_idx;

  logic [3:0]  w_req;
  logic [1:0]  w_row_nxt, w_col_nxt;
  logic [3:0]  w_idx_nxt;

  assign w_keys = {KEY_SEL, KEY_RIGHT, KEY_LEFT, KEY_DOWN, KEY_UP};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1    <= '1;
      r_sync2    <= '1;
      r_stable   <= '1;
      r_stable_d <= '1;
      r_evt      <= '0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= w_keys;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      r_evt      <= r_stable_d & ~r_stable;
      for (int k = 0; k < NKEYS; k++) begin
        if (r_sync2[k] == r_stable[k]) begin
          r_cnt[k] <= '0;
        end else if (r_cnt[k] == LP_TC) begin
          r_stable[k] <= r_sync2[k];
          r_cnt[k]    <= '0;
        end else begin
          r_cnt[k] <= r_cnt[k] + 1'b1;
        end
      end
    end
  end

  // a press landing on the strobe cycle is folded into this frame's move
  assign w_req = r_pend | r_evt[3:0];

  always_comb begin
    w_row_nxt = r_row;
    w_col_nxt = r_col;
    if (w_req[0] && !w_req[1]) begin
`ifdef HOVER_WRAP_EN
      w_row_nxt = (r_row == 2'd0) ? 2'd2 : r_row - 2'd1;
`else
      w_row_nxt = (r_row == 2'd0) ? 2'd0 : r_row - 2'd1;
`endif
    end else if (w_req[1] && !w_req[0]) begin
`ifdef HOVER_WRAP_EN
      w_row_nxt = (r_row == 2'd2) ? 2'd0 : r_row + 2'd1;
`else
      w_row_nxt = (r_row == 2'd2) ? 2'd2 : r_row + 2'd1;
`endif
    end
    if (w_req[2] && !w_req[3]) begin
`ifdef HOVER_WRAP_EN
      w_col_nxt = r_col - 2'd1;
`else
      w_col_nxt = (r_col == 2'd0) ? 2'd0 : r_col - 2'd1;
`endif
    end else if (w_req[3] && !w_req[2]) begin
`ifdef HOVER_WRAP_EN
      w_col_nxt = r_col + 2'd1;
`else
      w_col_nxt = (r_col == 2'd3) ? 2'd3 : r_col + 2'd1;
`endif
    end
  end

  // row*4 + col is just the concatenation
  assign w_idx_nxt = {w_row_nxt, w_col_nxt};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pend       <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_hover_idx  <= '0;
      r_hover_list <= 12'h001;
      r_sel_pulse  <= 1'b0;
      r_sel_idx    <= '0;
    end else begin
      if (FrameStart) begin
        r_pend       <= '0;
        r_row        <= w_row_nxt;
        r_col        <= w_col_nxt;
        r_hover_idx  <= w_idx_nxt;
        r_hover_list <= 12'b1 << w_idx_nxt;
      end else begin
        r_pend <= r_pend | r_evt[3:0];
      end
      r_sel_pulse <= r_evt[4];
      if (r_evt[4]) r_sel_idx <= r_hover_idx;
    end
  end

  assign HighlightedProductList = r_hover_list;
  assign HoverIndex             = r_hover_idx;
  assign SelectPulse            = r_sel_pulse;
  assign SelectIndex            = r_sel_idx;

endmodule

// File: tb/tb_hover_controller.sv
// Bench for hover_controller: directed scenarios plus random key sequences against a grid model.
module tb_hover_controller;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        KEY_UP = 1'b1, KEY_DOWN = 1'b1, KEY_LEFT = 1'b1, KEY_RIGHT = 1'b1, KEY_SEL = 1'b1;
  logic        FrameStart = 1'b0;
  logic [11:0] HighlightedProductList;
  logic [3:0]  HoverIndex;
  logic        SelectPulse;
  logic [3:0]  SelectIndex;

  int errors = 0;
  int checks = 0;

  int         m_row, m_col;
  logic [3:0] m_pend;
  int         m_sel_idx;

  hover_controller #(.DEBOUNCE_CYCLES(4), .DBC_WIDTH(3)) dut (
    .CLK(CLK), .RST(RST),
    .KEY_UP(KEY_UP), .KEY_DOWN(KEY_DOWN), .KEY_LEFT(KEY_LEFT),
    .KEY_RIGHT(KEY_RIGHT), .KEY_SEL(KEY_SEL),
    .FrameStart(FrameStart),
    .HighlightedProductList(HighlightedProductList),
    .HoverIndex(HoverIndex),
    .SelectPulse(SelectPulse),
    .SelectIndex(SelectIndex)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // bit 0 up, 1 down, 2 left, 3 right, 4 select; a 1 means held down
  task automatic set_keys(input logic [4:0] low);
    KEY_UP    = ~low[0];
    KEY_DOWN  = ~low[1];
    KEY_LEFT  = ~low[2];
    KEY_RIGHT = ~low[3];
    KEY_SEL   = ~low[4];
  endtask

  task automatic apply_reset();
    set_keys(5'b0);
    FrameStart = 1'b0;
    RST = 1'b1;
    repeat (3) tick();
    RST = 1'b0;
    tick();
    m_row = 0; m_col = 0; m_pend = '0; m_sel_idx = 0;
  endtask

  // clean press: held well past the debounce window, then released long enough to settle
  task automatic press(input logic [4:0] mask);
    set_keys(mask);
    repeat (10) tick();
    set_keys(5'b0);
    repeat (10) tick();
    m_pend = m_pend | mask[3:0];
    if (mask[4]) m_sel_idx = m_row * 4 + m_col;
  endtask

  task automatic model_commit();
    int dv, dh;
    dv = (m_pend[1] ? 1 : 0) - (m_pend[0] ? 1 : 0);
    dh = (m_pend[3] ? 1 : 0) - (m_pend[2] ? 1 : 0);
`ifdef HOVER_WRAP_EN
    m_row = (m_row + dv + 3) % 3;
    m_col = (m_col + dh + 4) % 4;
`else
    m_row = m_row + dv; if (m_row < 0) m_row = 0; if (m_row > 2) m_row = 2;
    m_col = m_col + dh; if (m_col < 0) m_col = 0; if (m_col > 3) m_col = 3;
`endif
    m_pend = '0;
  endtask

  task automatic check_pos(input string name);
    logic [3:0]  e_idx;
    logic [11:0] e_list;
    e_idx  = 4'(m_row * 4 + m_col);
    e_list = 12'b1 << e_idx;
    checks++;
    if (HoverIndex !== e_idx) begin
      errors++;
      $display("FAIL %s idx: got %0d expected %0d", name, HoverIndex, e_idx);
    end
    checks++;
    if (HighlightedProductList !== e_list) begin
      errors++;
      $display("FAIL %s list: got %h expected %h", name, HighlightedProductList, e_list);
    end
  endtask

  // checks the position is still held, strobes, then checks the committed move
  task automatic strobe_check(input string name);
    check_pos({name, "_pre"});
    FrameStart = 1'b1;
    tick();
    FrameStart = 1'b0;
    model_commit();
    check_pos(name);
  endtask

  task automatic test_reset();
    apply_reset();
    check_pos("reset");
    checks++;
    if (SelectPulse !== 1'b0) begin
      errors++; $display("FAIL reset_pulse: got %b expected 0", SelectPulse);
    end
    checks++;
    if (SelectIndex !== 4'd0) begin
      errors++; $display("FAIL reset_selidx: got %0d expected 0", SelectIndex);
    end
  endtask

  task automatic test_debounce();
    apply_reset();
    set_keys(5'b01000);
    repeat (3) tick();
    set_keys(5'b0);
    repeat (10) tick();
    strobe_check("glitch");
    press(5'b01000);
    strobe_check("debounced_right");
  endtask

  task automatic test_frame_align();
    apply_reset();
    press(5'b00010);
    press(5'b00010);
    strobe_check("double_down");
  endtask

  task automatic test_simultaneous();
    apply_reset();
    press(5'b01010);
    strobe_check("down_right");
    press(5'b01011);
    strobe_check("up_down_right");
  endtask

  task automatic test_edges();
    apply_reset();
    press(5'b01010); strobe_check("to5");
    press(5'b01010); strobe_check("to10");
    press(5'b01000); strobe_check("to11");
    press(5'b01000); strobe_check("edge_right");
    press(5'b00010); strobe_check("edge_down");
    press(5'b00001); strobe_check("edge_up");
    press(5'b00100); strobe_check("edge_left");
  endtask

  task automatic test_select();
    apply_reset();
    press(5'b01010); strobe_check("sel_to5");
    press(5'b01000); strobe_check("sel_to6");
    press(5'b01000);
    // select event lands exactly on the strobe edge carrying the pending RIGHT
    set_keys(5'b10000);
    repeat (7) tick();
    checks++;
    if (SelectPulse !== 1'b0) begin
      errors++; $display("FAIL sel_early: got %b expected 0", SelectPulse);
    end
    FrameStart = 1'b1;
    tick();
    FrameStart = 1'b0;
    model_commit();
    checks++;
    if (SelectPulse !== 1'b1) begin
      errors++; $display("FAIL sel_pulse: got %b expected 1", SelectPulse);
    end
    checks++;
    if (SelectIndex !== 4'd6) begin
      errors++; $display("FAIL sel_pre_move_idx: got %0d expected 6", SelectIndex);
    end
    check_pos("sel_move");
    tick();
    checks++;
    if (SelectPulse !== 1'b0) begin
      errors++; $display("FAIL sel_width: got %b expected 0", SelectPulse);
    end
    set_keys(5'b0);
    repeat (10) tick();
  endtask

  task automatic test_sel_reset();
    int pulses;
    apply_reset();
    press(5'b01000); strobe_check("rst_to1");
    set_keys(5'b10000);
    repeat (4) tick();
    RST = 1'b1;
    tick();
    set_keys(5'b0);
    tick();
    RST = 1'b0;
    m_row = 0; m_col = 0; m_pend = '0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (SelectPulse === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL sel_reset_pulses: got %0d expected 0", pulses);
    end
    checks++;
    if (SelectIndex !== 4'd0) begin
      errors++; $display("FAIL sel_reset_idx: got %0d expected 0", SelectIndex);
    end
    check_pos("sel_reset_pos");
  endtask

  task automatic test_random();
    apply_reset();
    for (int it = 0; it < 12; it++) begin
      int n;
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) press(5'($urandom_range(0, 31)));
      strobe_check($sformatf("rand%0d", it));
      checks++;
      if (SelectIndex !== 4'(m_sel_idx)) begin
        errors++;
        $display("FAIL rand%0d_selidx: got %0d expected %0d", it, SelectIndex, m_sel_idx);
      end
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_frame_align();
    test_simultaneous();
    test_edges();
    test_select();
    test_sel_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
